// File: rtl/block_header_msg_gen_pkg.sv
// Shared SHA-256 header constants, FSM encoding and byte-swap helper.
// Also used by the header and midstate blocks.
package block_header_msg_gen_pkg;

  localparam int unsigned SHA_WORD_WID   = 32;
  localparam int unsigned TAIL_WORDS     = 3;
  localparam int unsigned NONCE_WORD_IDX = 3;
  localparam int unsigned PAD_WORD_IDX   = 4;

  localparam logic [SHA_WORD_WID-1:0] SHA256_PAD_WORD = 32'h8000_0000;
  localparam logic [SHA_WORD_WID-1:0] BLK2_LEN_WORD   = 32'h0000_0280;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [SHA_WORD_WID-1:0] bswap32(input logic [SHA_WORD_WID-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/block_header_msg_gen_nonce_range_counter.sv
// Loadable nonce counter with a latched end value and terminal-count flag.
module nonce_range_counter #(
  parameter int unsigned WID = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [WID-1:0] iv_start,
  input  logic [WID-1:0] iv_end,
  input  logic           i_en,
  output logic [WID-1:0] ov_cnt,
  output logic           o_tc_c
);

  logic [WID-1:0] r_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_cnt <= '0;
      r_end  <= '0;
    end else if (i_load) begin
      ov_cnt <= iv_start;
      r_end  <= iv_end;
    end else if (i_en) begin
      ov_cnt <= ov_cnt + WID'(1);
    end
  end

  assign o_tc_c = (ov_cnt == r_end);

endmodule

// File: rtl/block_header_msg_gen.sv
// Builds the padded second SHA-256 block of an 80-byte header for each nonce
// in a range and streams one block per cycle into the message schedule.
module block_header_msg_gen
  import block_header_msg_gen_pkg::*;
#(
  parameter int unsigned WORD_NUM    = 16,
  parameter int unsigned DATA_WID    = 32,
  parameter bit          NONCE_BSWAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TAIL_WORDS*DATA_WID-1:0] iv_tail_data,
  input  logic [DATA_WID-1:0]          iv_nonce_start,
  input  logic [DATA_WID-1:0]          iv_nonce_end,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_hold,
  output logic [WORD_NUM*DATA_WID-1:0] ov_m_data,
  output logic                         o_m_data_vld,
  output logic [DATA_WID-1:0]          ov_nonce,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned TAIL_WID = TAIL_WORDS * DATA_WID;
  localparam int unsigned BLK_WID  = WORD_NUM * DATA_WID;

  state_e                r_state;
  logic [TAIL_WID-1:0]   r_tail;
  logic [DATA_WID-1:0]   w_cnt;
  logic                  w_tc;
  logic                  w_load;
  logic                  w_emit;
  logic                  w_en;
  logic [DATA_WID-1:0]   w_nonce_word;
  logic [BLK_WID-1:0]    w_block;

  assign w_load = (r_state == ST_IDLE) && i_start;
  assign w_emit = (r_state == ST_RUN) && !i_stop && !i_hold;
  assign w_en   = w_emit && !w_tc;

  nonce_range_counter #(
    .WID (DATA_WID)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .iv_start (iv_nonce_start),
    .iv_end   (iv_nonce_end),
    .i_en     (w_en),
    .ov_cnt   (w_cnt),
    .o_tc_c   (w_tc)
  );

  // Header is little-endian on the wire, so the nonce word is normally byte-swapped.
  assign w_nonce_word = NONCE_BSWAP ? DATA_WID'(bswap32(32'(w_cnt))) : w_cnt;

  always_comb begin
    w_block = '0;
    for (int unsigned i = 0; i < TAIL_WORDS; i++) begin
      w_block[DATA_WID*i +: DATA_WID] = r_tail[DATA_WID*i +: DATA_WID];
    end
    w_block[DATA_WID*NONCE_WORD_IDX +: DATA_WID] = w_nonce_word;
    w_block[DATA_WID*PAD_WORD_IDX +: DATA_WID]   = DATA_WID'(SHA256_PAD_WORD);
    w_block[DATA_WID*(WORD_NUM-1) +: DATA_WID]   = DATA_WID'(BLK2_LEN_WORD);
  end

  // Sweep control; stop takes priority over hold, done is suppressed on stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tail       <= '0;
      ov_m_data    <= '0;
      o_m_data_vld <= 1'b0;
      ov_nonce     <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_m_data_vld <= 1'b0;
      o_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tail  <= iv_tail_data;
            r_state <= ST_RUN;
            o_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (!i_hold) begin
            ov_m_data    <= w_block;
            o_m_data_vld <= 1'b1;
            ov_nonce     <= w_cnt;
            if (w_tc) begin
              r_state <= ST_DONE;
              o_busy  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          o_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_header_msg_gen.sv
// Bench for block_header_msg_gen: table of sweeps plus hold/stop/reset sequences,
// with a nonce scoreboard checked against both swapped and unswapped instances.
module tb_block_header_msg_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  tail;
  logic [31:0]  ns;
  logic [31:0]  ne;
  logic         i_start;
  logic         i_stop;
  logic         i_hold;
  logic [511:0] data0, data1;
  logic         vld0, vld1;
  logic [31:0]  nonce0, nonce1;
  logic         busy0, busy1;
  logic         done0, done1;

  always #5 clk = ~clk;

  block_header_msg_gen #(.WORD_NUM(16), .DATA_WID(32), .NONCE_BSWAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .iv_tail_data(tail), .iv_nonce_start(ns), .iv_nonce_end(ne),
    .i_start(i_start), .i_stop(i_stop), .i_hold(i_hold),
    .ov_m_data(data0), .o_m_data_vld(vld0), .ov_nonce(nonce0), .o_busy(busy0), .o_done(done0)
  );

  block_header_msg_gen #(.WORD_NUM(16), .DATA_WID(32), .NONCE_BSWAP(1'b0)) u_dut_nsw (
    .clk(clk), .rst(rst), .iv_tail_data(tail), .iv_nonce_start(ns), .iv_nonce_end(ne),
    .i_start(i_start), .i_stop(i_stop), .i_hold(i_hold),
    .ov_m_data(data1), .o_m_data_vld(vld1), .ov_nonce(nonce1), .o_busy(busy1), .o_done(done1)
  );

  typedef struct { logic [95:0] tail; logic [31:0] nonce; } exp_t;
  typedef struct { logic [95:0] tail; logic [31:0] s; logic [31:0] e; int nblk; } vec_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   vld_cnt = 0;
  int   done_cnt = 0;
  int   gap = 0;
  int   max_gap = 0;
  logic prev_vld = 1'b0;

  function automatic logic [511:0] exp_blk(input logic [95:0] t, input logic [31:0] n, input bit bsw);
    logic [511:0] b;
    b = '0;
    b[95:0]    = t;
    b[127:96]  = bsw ? {n[7:0], n[15:8], n[23:16], n[31:24]} : n;
    b[159:128] = 32'h8000_0000;
    b[511:480] = 32'h0000_0280;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Output monitor: every valid block is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (vld0 || vld1) chk("vld_pair", 512'(vld1), 512'(vld0));
    if (vld0) begin
      if (sb.size() == 0) begin
        chk("unexpected_block", 512'(1), 512'(0));
      end else begin
        m_e = sb.pop_front();
        chk("nonce", 512'(nonce0), 512'(m_e.nonce));
        chk("block_bswap", data0, exp_blk(m_e.tail, m_e.nonce, 1'b1));
        chk("block_noswap", data1, exp_blk(m_e.tail, m_e.nonce, 1'b0));
      end
      vld_cnt++;
      if (gap > max_gap) max_gap = gap;
      gap = 0;
    end else if (vld_cnt > 0) begin
      gap++;
    end
    if (done0) begin
      done_cnt++;
      chk("done_after_last_vld", 512'(prev_vld), 512'(1));
      chk("done_sb_empty", 512'(sb.size()), 512'(0));
    end
    prev_vld = vld0;
  end

  task automatic start_sweep(input logic [95:0] t, input logic [31:0] s, input logic [31:0] e);
    logic [31:0] n;
    n = s;
    for (int k = 0; k < 1000; k++) begin
      sb.push_back('{tail: t, nonce: n});
      if (n == e) break;
      n = n + 32'd1;
    end
    vld_cnt = 0;
    gap = 0;
    max_gap = 0;
    tail = t;
    ns = s;
    ne = e;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_stop = 1'b0;
    tail = {$urandom, $urandom, $urandom};
    ns = $urandom;
    ne = $urandom;
    chk("busy_after_start", 512'(busy0), 512'(1));
    chk("no_vld_first_edge", 512'(vld0), 512'(0));
  endtask

  task automatic wait_vld(input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (vld_cnt >= n) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wait_vld_timeout", 512'(0), 512'(1));
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 512'(seen), 512'(1));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[4];
  int   d0;

  initial begin
    vecs[0] = '{tail: {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, s: 32'h10, e: 32'h13, nblk: 4};
    vecs[1] = '{tail: 96'h0123_4567_89AB_CDEF_0F1E_2D3C, s: 32'hFFFF_FFFE, e: 32'h1, nblk: 4};
    vecs[2] = '{tail: 96'hDEAD_BEEF_0000_1111_2222_3333, s: 32'h55, e: 32'h55, nblk: 1};
    vecs[3] = '{tail: 96'h1357_9BDF_2468_ACE0_F0F0_0F0F, s: 32'h1234_5670, e: 32'h1234_5677, nblk: 8};

    rst = 1'b1;
    tail = '0; ns = '0; ne = '0;
    i_start = 1'b0; i_stop = 1'b0; i_hold = 1'b0;
    tick(2);
    chk("rst_data", data0, 512'(0));
    chk("rst_vld", 512'(vld0), 512'(0));
    chk("rst_nonce", 512'(nonce0), 512'(0));
    chk("rst_busy", 512'(busy0), 512'(0));
    chk("rst_done", 512'(done0), 512'(0));
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      start_sweep(vecs[v].tail, vecs[v].s, vecs[v].e);
      @(posedge clk); #1;
      chk("first_block_latency", 512'(vld0), 512'(1));
      wait_done(64);
      chk("busy_low_at_done", 512'(busy0), 512'(0));
      chk("vld_low_at_done", 512'(vld0), 512'(0));
      tick(3);
      chk("sweep_block_count", 512'(vld_cnt), 512'(vecs[v].nblk));
      chk("sweep_done_pulses", 512'(done_cnt - d0), 512'(1));
      chk("sweep_sb_empty", 512'(sb.size()), 512'(0));
      chk("sweep_busy_idle", 512'(busy0), 512'(0));
    end

    // Hold for three cycles after the second block.
    d0 = done_cnt;
    start_sweep(96'hAAAA_0000_BBBB_1111_CCCC_2222, 32'h0, 32'h9);
    wait_vld(2, 50);
    i_hold = 1'b1;
    tick(3);
    i_hold = 1'b0;
    wait_done(64);
    tick(2);
    chk("hold_block_count", 512'(vld_cnt), 512'(10));
    chk("hold_gap", 512'(max_gap), 512'(3));
    chk("hold_sb_empty", 512'(sb.size()), 512'(0));
    chk("hold_done_pulses", 512'(done_cnt - d0), 512'(1));

    // Hold and stop together: stop wins.
    d0 = done_cnt;
    start_sweep(96'h1111_2222_3333_4444_5555_6666, 32'h0, 32'h9);
    wait_vld(2, 50);
    i_hold = 1'b1;
    i_stop = 1'b1;
    tick(1);
    i_hold = 1'b0;
    i_stop = 1'b0;
    chk("holdstop_busy", 512'(busy0), 512'(0));
    tick(3);
    chk("holdstop_block_count", 512'(vld_cnt), 512'(2));
    chk("holdstop_no_done", 512'(done_cnt - d0), 512'(0));
    chk("holdstop_vld_low", 512'(vld0), 512'(0));
    sb.delete();

    // Stop after the fifth block, then a fresh sweep with stop asserted alongside start.
    d0 = done_cnt;
    start_sweep(96'h7777_8888_9999_AAAA_BBBB_CCCC, 32'h0, 32'd99);
    wait_vld(5, 50);
    i_stop = 1'b1;
    tick(1);
    i_stop = 1'b0;
    chk("stop_busy", 512'(busy0), 512'(0));
    tick(3);
    chk("stop_block_count", 512'(vld_cnt), 512'(5));
    chk("stop_no_done", 512'(done_cnt - d0), 512'(0));
    sb.delete();
    d0 = done_cnt;
    i_stop = 1'b1;
    start_sweep(96'hFEDC_BA98_7654_3210_0F0F_F0F0, 32'h20, 32'h22);
    wait_done(64);
    tick(2);
    chk("restart_block_count", 512'(vld_cnt), 512'(3));
    chk("restart_sb_empty", 512'(sb.size()), 512'(0));
    chk("restart_done_pulses", 512'(done_cnt - d0), 512'(1));

    // i_start during RUN is ignored; async reset mid-cycle clears outputs at once.
    d0 = done_cnt;
    start_sweep(96'h0000_1111_2222_3333_4444_5555, 32'h200, 32'h2FF);
    wait_vld(3, 50);
    ns = 32'h900;
    ne = 32'h901;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_vld(6, 50);
    chk("busy_mid_sweep", 512'(busy0), 512'(1));
    rst = 1'b1;
    #1;
    chk("arst_data", data0, 512'(0));
    chk("arst_vld", 512'(vld0), 512'(0));
    chk("arst_nonce", 512'(nonce0), 512'(0));
    chk("arst_busy", 512'(busy0), 512'(0));
    chk("arst_done", 512'(done0), 512'(0));
    tick(1);
    rst = 1'b0;
    sb.delete();
    tick(5);
    chk("arst_no_done", 512'(done_cnt - d0), 512'(0));
    chk("arst_stays_idle", 512'(vld0), 512'(0));
    chk("arst_busy_idle", 512'(busy0), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
